// File: rtl/regfile_sb_if.sv
// Bundles the register-file read, write and scoreboard signals between decode
// and the register file so both sides agree on widths through one parameter set.
interface regfile_sb_if #(
    parameter int N     = 32,
    parameter int NREGS = 32
);
    localparam int AW = $clog2(NREGS);

    logic [AW-1:0] ra;
    logic [AW-1:0] rb;
    logic [N-1:0]  rda;
    logic [N-1:0]  rdb;

    logic          we0;
    logic [AW-1:0] rw0;
    logic [N-1:0]  wd0;

    logic          we1;
    logic [AW-1:0] rw1;
    logic [N-1:0]  wd1;

    logic          busy_set;
    logic [AW-1:0] busy_rd;

    logic          hazard_a;
    logic          hazard_b;
    logic          busy_any;

    // Master is the decode/writeback side, slave is the register file itself.
    modport master (
        output ra, rb, we0, rw0, wd0, we1, rw1, wd1, busy_set, busy_rd,
        input  rda, rdb, hazard_a, hazard_b, busy_any
    );

    modport slave (
        input  ra, rb, we0, rw0, wd0, we1, rw1, wd1, busy_set, busy_rd,
        output rda, rdb, hazard_a, hazard_b, busy_any
    );
endinterface

// File: rtl/regfile_sb.sv
// Two-read/two-write register file with write-to-read bypass, an optional
// hardwired zero register and a busy scoreboard for long-latency results.
module regfile_sb #(
    parameter int N        = 32,
    parameter int NREGS    = 32,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic         clk,
    input  logic         reset,
    regfile_sb_if.slave  bus
);
    logic [N-1:0]     regs_q [NREGS];
    logic [N-1:0]     regs_d [NREGS];
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic             wrEn0;
    logic             wrEn1;
    logic             setEn;

    function automatic logic isZeroAddr(input logic [AW-1:0] addr);
        return (ZERO_REG != 0) && (addr == '0);
    endfunction

    // Port 1 is checked first so it overrides port 0 on a shared address.
    function automatic logic [N-1:0] bypassRead(
        input logic [AW-1:0] addr,
        input logic [N-1:0]  stored,
        input logic          en0,
        input logic [AW-1:0] addr0,
        input logic [N-1:0]  data0,
        input logic          en1,
        input logic [AW-1:0] addr1,
        input logic [N-1:0]  data1
    );
        if (isZeroAddr(addr))
            return '0;
        if (en1 && addr1 == addr)
            return data1;
        if (en0 && addr0 == addr)
            return data0;
        return stored;
    endfunction

    always_comb begin
        wrEn0 = bus.we0 && !isZeroAddr(bus.rw0);
        wrEn1 = bus.we1 && !isZeroAddr(bus.rw1);
        setEn = bus.busy_set && !isZeroAddr(bus.busy_rd);
    end

    always_comb begin
        regs_d = regs_q;
        if (wrEn0)
            regs_d[bus.rw0] = bus.wd0;
        if (wrEn1)
            regs_d[bus.rw1] = bus.wd1;
    end

    // A new issue to the register that is retiring this cycle keeps it busy.
    always_comb begin
        busy_d = busy_q;
        if (wrEn1)
            busy_d[bus.rw1] = 1'b0;
        if (setEn)
            busy_d[bus.busy_rd] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++)
                regs_q[i] <= '0;
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    always_comb begin
        bus.rda = bypassRead(bus.ra, regs_q[bus.ra], wrEn0, bus.rw0, bus.wd0,
                             wrEn1, bus.rw1, bus.wd1);
        bus.rdb = bypassRead(bus.rb, regs_q[bus.rb], wrEn0, bus.rw0, bus.wd0,
                             wrEn1, bus.rw1, bus.wd1);
    end

    // A port-1 result landing this cycle is already bypassed, so it clears the stall.
    always_comb begin
        bus.hazard_a = busy_q[bus.ra] && !(bus.we1 && bus.rw1 == bus.ra);
        bus.hazard_b = busy_q[bus.rb] && !(bus.we1 && bus.rw1 == bus.rb);
        bus.busy_any = |busy_q;
    end
endmodule

// File: tb/tb_regfile_sb.sv
// Directed and pseudo-random stimulus for regfile_sb, checked every cycle
// against an architectural model plus hand-computed literal expectations.
module tb_regfile_sb;
    logic clk;
    logic reset;
    logic checkEn;
    int   checkCount;
    int   passCount;

    logic [31:0] mdlRegs [32];
    logic [31:0] mdlBusy;

    regfile_sb_if #(.N(32), .NREGS(32)) bus ();

    regfile_sb #(.N(32), .NREGS(32), .ZERO_REG(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual === expected)
            passCount++;
        else
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    endtask

    task automatic applyStimulus(
        input logic       rst,
        input logic [4:0] ra,
        input logic [4:0] rb,
        input logic       we0,
        input logic [4:0] rw0,
        input logic [31:0] wd0,
        input logic       we1,
        input logic [4:0] rw1,
        input logic [31:0] wd1,
        input logic       bset,
        input logic [4:0] brd
    );
        @(posedge clk);
        #2;
        reset        = rst;
        bus.ra       = ra;
        bus.rb       = rb;
        bus.we0      = we0;
        bus.rw0      = rw0;
        bus.wd0      = wd0;
        bus.we1      = we1;
        bus.rw1      = rw1;
        bus.wd1      = wd1;
        bus.busy_set = bset;
        bus.busy_rd  = brd;
    endtask

    // Architectural state: register 0 is never written and never busy.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++)
                mdlRegs[i] <= 32'h0;
            mdlBusy <= 32'h0;
        end else begin
            if (bus.we0 && bus.rw0 != 5'd0 && !(bus.we1 && bus.rw1 == bus.rw0))
                mdlRegs[bus.rw0] <= bus.wd0;
            if (bus.we1 && bus.rw1 != 5'd0)
                mdlRegs[bus.rw1] <= bus.wd1;
            for (int i = 1; i < 32; i++) begin
                if (bus.busy_set && bus.busy_rd == 5'(i))
                    mdlBusy[i] <= 1'b1;
                else if (bus.we1 && bus.rw1 == 5'(i))
                    mdlBusy[i] <= 1'b0;
            end
        end
    end

    function automatic logic [31:0] expRead(input logic [4:0] a);
        if (a == 5'd0)
            return 32'h0;
        if (bus.we1 && bus.rw1 == a)
            return bus.wd1;
        if (bus.we0 && bus.rw0 == a)
            return bus.wd0;
        return mdlRegs[a];
    endfunction

    function automatic logic [31:0] expHazard(input logic [4:0] a);
        return {31'd0, mdlBusy[a] && !(bus.we1 && bus.rw1 == a)};
    endfunction

    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("model_rda", bus.rda, expRead(bus.ra));
            checkOutput("model_rdb", bus.rdb, expRead(bus.rb));
            checkOutput("model_hazard_a", {31'd0, bus.hazard_a}, expHazard(bus.ra));
            checkOutput("model_hazard_b", {31'd0, bus.hazard_b}, expHazard(bus.rb));
            checkOutput("model_busy_any", {31'd0, bus.busy_any}, {31'd0, mdlBusy != 32'h0});
        end
    end

    initial begin
        checkEn      = 1'b0;
        checkCount   = 0;
        passCount    = 0;
        reset        = 1'b1;
        bus.ra       = '0;
        bus.rb       = '0;
        bus.we0      = 1'b0;
        bus.rw0      = '0;
        bus.wd0      = '0;
        bus.we1      = 1'b0;
        bus.rw1      = '0;
        bus.wd1      = '0;
        bus.busy_set = 1'b0;
        bus.busy_rd  = '0;

        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 32; i++) begin
            applyStimulus(0, 5'(i), 5'(31 - i), 0, 0, 0, 0, 0, 0, 0, 0);
            checkEn = 1'b1;
            #2;
            checkOutput("reset_rda", bus.rda, 32'h0);
            checkOutput("reset_rdb", bus.rdb, 32'h0);
        end
        checkOutput("reset_busy_any", {31'd0, bus.busy_any}, 32'h0);

        applyStimulus(0, 0, 0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        applyStimulus(0, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2 checkOutput("write_r5", bus.rda, 32'hDEADBEEF);

        applyStimulus(0, 3, 0, 1, 3, 32'h11, 1, 3, 32'h22, 0, 0);
        #2 checkOutput("bypass_port1_wins", bus.rda, 32'h22);
        applyStimulus(0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2 checkOutput("store_port1_wins", bus.rda, 32'h22);

        applyStimulus(0, 0, 0, 1, 0, 32'hFF, 0, 0, 0, 0, 0);
        #2 checkOutput("zero_no_bypass", bus.rda, 32'h0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        #2 checkOutput("zero_not_stored", bus.rda, 32'h0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2 checkOutput("zero_never_busy", {31'd0, bus.busy_any}, 32'h0);

        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7);
        #2 checkOutput("set_not_visible_same_cycle", {31'd0, bus.busy_any}, 32'h0);
        applyStimulus(0, 0, 7, 0, 0, 0, 0, 0, 0, 0, 0);
        #2 checkOutput("busy7_hazard_b", {31'd0, bus.hazard_b}, 32'h1);
        checkOutput("busy7_busy_any", {31'd0, bus.busy_any}, 32'h1);
        applyStimulus(0, 0, 7, 0, 0, 0, 1, 7, 32'h1234, 0, 0);
        #2 checkOutput("retire7_hazard_b", {31'd0, bus.hazard_b}, 32'h0);
        checkOutput("retire7_rdb", bus.rdb, 32'h1234);
        applyStimulus(0, 0, 7, 0, 0, 0, 0, 0, 0, 0, 0);
        #2 checkOutput("retire7_idle", {31'd0, bus.busy_any}, 32'h0);

        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9);
        applyStimulus(0, 9, 0, 0, 0, 0, 1, 9, 32'hABCD, 1, 9);
        #2 checkOutput("collide_resolved_now", {31'd0, bus.hazard_a}, 32'h0);
        applyStimulus(0, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2 checkOutput("collide_set_wins", {31'd0, bus.hazard_a}, 32'h1);
        checkOutput("collide_stored", bus.rda, 32'hABCD);

        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 6);
        applyStimulus(1, 0, 0, 1, 4, 32'h99, 0, 0, 0, 1, 5);
        applyStimulus(0, 4, 6, 0, 0, 0, 0, 0, 0, 0, 0);
        #2 checkOutput("rst_mid_busy_any", {31'd0, bus.busy_any}, 32'h0);
        checkOutput("rst_mid_rda", bus.rda, 32'h0);
        checkOutput("rst_mid_hazard_b", {31'd0, bus.hazard_b}, 32'h0);
        applyStimulus(0, 4, 0, 0, 0, 0, 1, 4, 32'h44, 0, 0);
        applyStimulus(0, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2 checkOutput("rst_mid_write4", bus.rda, 32'h44);
        checkOutput("rst_mid_idle", {31'd0, bus.busy_any}, 32'h0);

        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2);
        applyStimulus(0, 0, 0, 1, 2, 32'h5, 0, 0, 0, 0, 0);
        applyStimulus(0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2 checkOutput("port0_busy_rda", bus.rda, 32'h5);
        checkOutput("port0_busy_hazard", {31'd0, bus.hazard_a}, 32'h1);

        for (int c = 0; c < 400; c++) begin
            applyStimulus($urandom_range(0, 39) == 0,
                          5'($urandom_range(0, 9)), 5'($urandom_range(0, 31)),
                          1'($urandom_range(0, 1)), 5'($urandom_range(0, 9)), $urandom(),
                          1'($urandom_range(0, 1)), 5'($urandom_range(0, 9)), $urandom(),
                          1'($urandom_range(0, 1)), 5'($urandom_range(0, 9)));
        end

        @(posedge clk);
        #3;
        @(posedge clk);
        #3;
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor of the ID-stage register file for the RSA decryption ASIP.
- Two read ports and two write ports:
  - Port 0: in-order pipeline writeback.
  - Port 1: long-latency unit writeback (modular multiply/exponentiate).
- Adds write-to-read bypass, an optional hardwired zero register, and a per-register busy scoreboard. The decode stage uses the scoreboard to stall on operands still owned by the long-latency unit.

Parameters:
- N, 32: data width in bits.
- NREGS, 32: number of registers; power of two, at least 2.
- ZERO_REG, 1: when 1, register 0 reads as zero, ignores writes, and is never busy.
- AW, $clog2(NREGS): register address width (derived; not overridden).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- ra  input  AW  source register a.
- rb  input  AW  source register b.
- rda  output  N  data for ra, including bypass.
- rdb  output  N  data for rb, including bypass.
- we0  input  1  write enable, pipeline writeback port.
- rw0  input  AW  destination register, port 0.
- wd0  input  N  write data, port 0.
- we1  input  1  write enable, long-latency unit port.
- rw1  input  AW  destination register, port 1.
- wd1  input  N  write data, port 1.
- busy_set  input  1  marks register busy_rd as pending (long-latency op issued).
- busy_rd  input  AW  register to mark busy.
- hazard_a  output  1  ra is pending and not being resolved this cycle.
- hazard_b  output  1  rb is pending and not being resolved this cycle.
- busy_any  output  1  OR of all busy bits (drain/idle indication).

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (reset).
- Reset:
  - On a rising edge with reset=1, all registers clear to 0 and all busy bits clear.
  - Writes and busy_set in that same cycle are discarded.
  - After reset: rda=rdb=0 for every address, hazard_a=hazard_b=0, busy_any=0.
  - Reset mid-operation drops all pending busy state; a later we1 to a formerly busy register is an ordinary write.
- Writes:
  - Storage updates at the rising edge.
  - Both ports may write different registers in the same cycle.
  - When rw0==rw1 with both enables high, port 1 wins.
- Reads: combinational, zero-cycle latency. Priority for rda (rdb identical with rb):
  1. ZERO_REG=1 and ra==0: output 0.
  2. we1 && rw1==ra: output wd1.
  3. we0 && rw0==ra: output wd0.
  4. Otherwise: stored value.
- Zero register (ZERO_REG=1):
  - Writes to address 0 are ignored on both ports and are not bypassed.
  - busy_set with busy_rd==0 is ignored.
- Scoreboard, at the rising edge:
  - busy[busy_rd] is set when busy_set=1.
  - busy[rw1] is cleared when we1=1.
  - If busy_set and we1 target the same register in the same cycle, set wins: a new op is issued while the old result retires.
- we0 never changes busy bits. Writing a busy register via port 0 updates storage; busy stays set until port 1 writes it.
- hazard_a = busy[ra] && !(we1 && rw1==ra). Combinational; same-cycle port-1 completion removes the stall. hazard_b is identical with rb.
- hazard_a and hazard_b do not consider same-cycle busy_set; the new busy bit is visible from the next cycle.
- busy_any is combinational from the registered busy bits.
- Address wrap: no wrap; every AW-bit address is a valid register since NREGS is a power of two.

Test Plan:
- Reset, then read all addresses: rda=rdb=0, busy_any=0. Write r5=0xDEADBEEF via port 0, then read ra=5 next cycle: rda=0xDEADBEEF.
- Bypass: same cycle we0 rw0=3 wd0=0x11 and we1 rw1=3 wd1=0x22 with ra=3: rda=0x22. Next cycle ra=3: rda=0x22, since port 1 wins storage.
- Zero register (ZERO_REG=1): we0 rw0=0 wd0=0xFF with ra=0: rda=0 in the same and next cycle. busy_set busy_rd=0: busy_any stays 0.
- Scoreboard:
  - busy_set busy_rd=7, then rb=7 next cycle: hazard_b=1, busy_any=1.
  - Later cycle with we1 rw1=7 wd1=0x1234: hazard_b=0 and rdb=0x1234 in that cycle.
  - Following cycle: busy_any=0.
- Set/clear collision: r9 busy, then same cycle we1 rw1=9 and busy_set busy_rd=9. Next cycle: hazard_a=1 for ra=9, stored value equals wd1.
- Reset mid-op: r4 and r6 busy, then reset=1 for one cycle. Afterwards busy_any=0, rda=0 for ra=4, and a following we1 rw1=4 stores normally.
- Port-0 write to busy register: r2 busy, we0 rw0=2 wd0=0x5. Next cycle rda=0x5 for ra=2 and hazard_a=1.
